// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: turns a single-bit spike train into numbers.
//   - Counts spikes over a programmable window of clock cycles. Windows run
//     back-to-back while enable is high. Each completed window is offered to
//     the consumer through a valid/ready handshake.
//   - Measures the interval between consecutive spikes. This path is
//     independent of the window FSM.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   enable           run windows back-to-back while high
//   window_len       window length in cycles, sampled at each window start
//   spike            spike input; each high cycle is one spike
//   rate, rate_sat   spike count of the last completed window, and its saturation flag
//   out_valid        rate/rate_sat hold an unconsumed result
//   out_ready        consumer accepts the result when out_valid is also high
//   overrun          sticky: a result was overwritten before it was consumed
//   isi, isi_valid   last inter-spike interval (saturating); valid after two spikes
//   busy             a window is being counted
module spike_rate_decoder #(
    parameter int unsigned WIN_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    input  logic             spike,
    output logic [CNT_W-1:0] rate,
    output logic             rate_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [WIN_W-1:0] isi,
    output logic             isi_valid,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WIN_W-1:0] WIN_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [WIN_W-1:0] len;
    logic [WIN_W-1:0] cyc;
    logic [CNT_W-1:0] acc;
    logic             sat;
    logic [WIN_W-1:0] t;
    logic             seen_one;

    logic             start_c;
    logic             last_c;
    logic             rearm_c;
    logic [CNT_W-1:0] acc_upd_c;
    logic             sat_upd_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_c) state_next = COUNT;
            COUNT:   if (last_c && !rearm_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy      = (state == COUNT);
        start_c   = (state == IDLE) && enable && (window_len != '0);
        last_c    = (state == COUNT) && (cyc == len - WIN_W'(1));
        rearm_c   = last_c && enable && (window_len != '0);
        // Count includes this cycle's spike; hold at max and flag the attempt.
        acc_upd_c = (spike && (acc != CNT_MAX)) ? acc + CNT_W'(1) : acc;
        sat_upd_c = sat | (spike && (acc == CNT_MAX));
    end

    // Window counters; a (re)start clears them so windows abut with no gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len <= '0;
            cyc <= '0;
            acc <= '0;
            sat <= 1'b0;
        end else if (start_c || rearm_c) begin
            len <= window_len;
            cyc <= '0;
            acc <= '0;
            sat <= 1'b0;
        end else if (state == COUNT) begin
            cyc <= cyc + WIN_W'(1);
            acc <= acc_upd_c;
            sat <= sat_upd_c;
        end
    end

    // Result register and handshake; a new result always wins over a pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate      <= '0;
            rate_sat  <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (last_c) begin
            rate      <= acc_upd_c;
            rate_sat  <= sat_upd_c;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Inter-spike interval: free-running saturating timer reset by each spike
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t         <= '0;
            seen_one  <= 1'b0;
            isi       <= '0;
            isi_valid <= 1'b0;
        end else if (spike) begin
            t        <= '0;
            seen_one <= 1'b1;
            if (seen_one) begin
                isi       <= (t == WIN_MAX) ? WIN_MAX : t + WIN_W'(1);
                isi_valid <= 1'b1;
            end
        end else if (t != WIN_MAX) begin
            t <= t + WIN_W'(1);
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed table, corner sequences and random
// stimulus, all compared every cycle against a window/interval reference model.
module tb_spike_rate_decoder;

    localparam int unsigned WIN_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int CMAX = 15;
    localparam int WMAX = 255;
    localparam int HN   = 8192;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIN_W-1:0] window_len;
    logic             spike;
    logic [CNT_W-1:0] rate;
    logic             rate_sat;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic [WIN_W-1:0] isi;
    logic             isi_valid;
    logic             busy;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .window_len (window_len),
        .spike      (spike),
        .rate       (rate),
        .rate_sat   (rate_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .isi        (isi),
        .isi_valid  (isi_valid),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: spike history per cycle, window bounds, result slot.
    bit hist [HN];
    int n;
    bit m_run;
    int m_start, m_len;
    bit e_valid, e_sat, e_ovr, e_isiv, have_last;
    int e_rate, e_isi, last_sp;

    typedef struct {
        bit en;
        int wl;
        bit sp;
        bit rdy;
        bit ev;
        int er;
        bit eb;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; e_valid = 0; e_rate = 0; e_sat = 0; e_ovr = 0;
        e_isi = 0; e_isiv = 0; have_last = 0;
    endtask

    task automatic check_all();
        check("busy", 32'(busy), 32'(m_run));
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("rate", 32'(rate), e_rate);
        check("rate_sat", 32'(rate_sat), 32'(e_sat));
        check("overrun", 32'(overrun), 32'(e_ovr));
        check("isi_valid", 32'(isi_valid), 32'(e_isiv));
        check("isi", 32'(isi), e_isi);
    endtask

    // One clock: sample driven inputs, advance the model, compare after the edge.
    task automatic step();
        bit en, sp, rdy, res, r_sat;
        int wl, cnt, r_rate;
        en = enable; sp = spike; rdy = out_ready; wl = int'(window_len);
        res = 0; r_sat = 0; r_rate = 0;
        @(posedge clk);
        hist[n % HN] = sp;
        if (m_run && n == m_start + m_len) begin
            cnt = 0;
            for (int c = m_start + 1; c <= n; c++) cnt += int'(hist[c % HN]);
            res = 1;
            r_rate = (cnt > CMAX) ? CMAX : cnt;
            r_sat  = (cnt > CMAX);
            if (en && wl != 0) begin
                m_start = n; m_len = wl;
            end else begin
                m_run = 0;
            end
        end else if (!m_run && en && wl != 0) begin
            m_run = 1; m_start = n; m_len = wl;
        end
        if (res) begin
            if (e_valid && !rdy) e_ovr = 1;
            e_valid = 1; e_rate = r_rate; e_sat = r_sat;
        end else if (e_valid && rdy) begin
            e_valid = 0;
        end
        if (sp) begin
            if (have_last) begin
                e_isi  = (n - last_sp > WMAX) ? WMAX : n - last_sp;
                e_isiv = 1;
            end
            last_sp = n; have_last = 1;
        end
        n++;
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rate", 32'(rate), 0);
        check("rst_isi_valid", 32'(isi_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_isi", 32'(isi), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input bit en, input int wl, input bit sp, input bit rdy);
        enable = en; window_len = WIN_W'(wl); spike = sp; out_ready = rdy;
    endtask

    task automatic drain();
        int k;
        k = 0;
        drive(0, 0, 0, 1);
        while ((m_run || e_valid) && k < 400) begin
            step();
            k++;
        end
        check("drain_timeout", 32'(busy | out_valid), 0);
    endtask

    initial begin
        bit sp_seq [8];

        // Directed window: len 10, spikes on window cycles 2, 5, 9.
        tbl[0] = '{en:1, wl:10, sp:0, rdy:0, ev:0, er:0, eb:1};
        for (int i = 1; i <= 10; i++)
            tbl[i] = '{en:1, wl:10, sp:(i == 2 || i == 5 || i == 9), rdy:0,
                       ev:(i == 10), er:(i == 10) ? 3 : 0, eb:1};
        tbl[11] = '{en:0, wl:10, sp:0, rdy:1, ev:0, er:3, eb:1};

        n = 0;
        model_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].en, tbl[i].wl, tbl[i].sp, tbl[i].rdy);
            step();
            check("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
            check("tbl_rate", 32'(rate), tbl[i].er);
            check("tbl_busy", 32'(busy), 32'(tbl[i].eb));
        end
        drain();

        // Spike held high for a 255-cycle window saturates the 4-bit count.
        drive(1, 255, 1, 0);
        step();
        drive(0, 255, 1, 0);
        repeat (255) step();
        spike = 1'b0;
        check("sat_rate", 32'(rate), 15);
        check("sat_flag", 32'(rate_sat), 1);
        check("sat_valid", 32'(out_valid), 1);
        drain();

        // Two back-to-back len-4 windows with no consumer: overrun.
        sp_seq = '{0, 1, 0, 0, 1, 0, 1, 0};
        drive(1, 4, 0, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(i < 4, 4, sp_seq[i], 0);
            step();
        end
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_rate", 32'(rate), 2);
        drive(0, 0, 0, 1);
        step();
        check("ovr_pop_valid", 32'(out_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);
        out_ready = 1'b0;

        // Inter-spike intervals 7, 1, then a saturated gap.
        drive(0, 0, 1, 0); step();
        spike = 1'b0; repeat (6) step();
        spike = 1'b1; step();
        check("isi_7", 32'(isi), 7);
        check("isi_valid", 32'(isi_valid), 1);
        step();
        check("isi_1", 32'(isi), 1);
        spike = 1'b0; repeat (300) step();
        spike = 1'b1; step();
        check("isi_sat", 32'(isi), 255);
        spike = 1'b0;

        // Zero-length window request stays idle.
        drive(1, 0, 0, 0);
        repeat (3) step();
        check("zero_busy", 32'(busy), 0);
        check("zero_valid", 32'(out_valid), 0);

        // window_len changes mid-window: current keeps 6, next uses 3.
        drive(1, 6, 0, 0);
        step();
        for (int i = 1; i <= 6; i++) begin
            drive(1, 3, i == 3, 0);
            step();
        end
        check("len6_valid", 32'(out_valid), 1);
        check("len6_rate", 32'(rate), 1);
        check("len6_busy", 32'(busy), 1);
        drive(0, 3, 0, 1); step();
        check("len3_pop", 32'(out_valid), 0);
        drive(0, 3, 1, 0); step();
        drive(0, 3, 0, 0); step();
        check("len3_valid", 32'(out_valid), 1);
        check("len3_rate", 32'(rate), 1);
        check("len3_busy", 32'(busy), 0);

        // Reset in the middle of a 20-cycle window discards it.
        drive(1, 20, 0, 0);
        step();
        drive(0, 20, 1, 0);
        repeat (5) step();
        do_reset();
        drive(1, 5, 0, 0);
        step();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 5, i == 1 || i == 4, 0);
            step();
        end
        check("post_rst_rate", 32'(rate), 2);
        check("post_rst_valid", 32'(out_valid), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) != 0,
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20)),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0);
            step();
            if (i == 1500) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
